// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and state encoding for the 32-point SDF FFT stages
package fft_pkg;
  localparam int FRAME_LEN = 32;
  localparam int HALF_LEN = 16;
  localparam logic [5:0] TW16_ROM_BASE = 6'd32;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
endpackage

// File: rtl/sdf_frame_counter.sv
// sdf_frame_counter: frame sample counter with strobe enable and flush-end clear
module sdf_frame_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             half_end
);
  assign half_end = &cnt[CNT_W-2:0];
  // count accepted strobes, wrapping at the frame length; clear when a flush ends
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/sdf16_stage_ctrl.sv
// sdf16_stage_ctrl: sequencer for the 16-deep radix-2 SDF stage of the 32-point FFT
module sdf16_stage_ctrl
  import fft_pkg::*;
#(
  parameter logic [5:0] ROM_BASE = TW16_ROM_BASE,
  parameter int         CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush_req,
  output logic             dl_shift,
  output logic             bf_en,
  output logic [5:0]       rom_addr,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic half_end, s, fin, flush_pend, busy;
  assign in_ready = !(state == FLUSH || (state == RUN && cnt == '0 && flush_pend));
  assign s = (in_valid && in_ready) || state == FLUSH;
  assign fin = state == FLUSH && half_end;
  assign busy = state == RUN || state == FLUSH;
  sdf_frame_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en(s),
    .clr(fin),
    .cnt(cnt),
    .half_end(half_end)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: prime half a frame, stream, then drain on a pending flush at the frame boundary
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = s ? FILL : IDLE;
      FILL:  state_n = (s && half_end) ? RUN : FILL;
      RUN:   state_n = (cnt == '0 && flush_pend) ? FLUSH : RUN;
      FLUSH: state_n = half_end ? IDLE : FLUSH;
    endcase
  end
  // remember a flush request until the drain it asks for has completed
  always_ff @(posedge clk or posedge rst)
    if (rst) flush_pend <= 1'b0;
    else if (fin) flush_pend <= 1'b0;
    else if (flush_req && (state == FILL || state == RUN)) flush_pend <= 1'b1;
  // registered datapath controls; mode, twiddle address and index hold between strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dl_shift  <= 1'b0;
      bf_en     <= 1'b0;
      rom_addr  <= ROM_BASE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_shift  <= s;
      out_valid <= s && busy;
      out_last  <= s && busy && !cnt[CNT_W-1] && half_end;
      done      <= fin;
      if (s) begin
        bf_en    <= cnt[CNT_W-1];
        rom_addr <= cnt[CNT_W-1] ? ROM_BASE : ROM_BASE + 6'(cnt[CNT_W-2:0]);
        out_idx  <= {~cnt[CNT_W-1], cnt[CNT_W-2:0]};
      end
    end
endmodule
